// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester byte memory arbiter, 3-cycle IDLE/ADDR/DATA access
// Optional ARB_FIXED_PRIO_EN: B wins ties instead of round-robin.
module mem_arbiter #(
  parameter int ADDR_W    = 20,
  parameter bit LAST_INIT = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_we,
  input  logic [7:0]        a_o_data,
  output logic              a_ack,
  output logic [7:0]        a_i_data,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_address,
  output logic              b_ack,
  output logic [7:0]        b_i_data,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        o_data,
  output logic              we,
  input  logic [7:0]        i_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [7:0]        o_data_q, o_data_d;
  logic              we_q, we_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [7:0]        a_i_data_q, a_i_data_d;
  logic [7:0]        b_i_data_q, b_i_data_d;
  logic              last_q, last_d;   // 1 = B was granted last
  logic              win_b_q, win_b_d;
  logic              grant_b;

`ifdef ARB_FIXED_PRIO_EN
  assign grant_b = b_req;
`else
  assign grant_b = b_req && (!a_req || !last_q);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (a_req || b_req) state_d = S_ADDR;
      S_ADDR:  state_d = S_DATA;
      S_DATA:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    address_d  = address_q;
    o_data_d   = o_data_q;
    we_d       = 1'b0;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    a_i_data_d = a_i_data_q;
    b_i_data_d = b_i_data_q;
    last_d     = last_q;
    win_b_d    = win_b_q;
    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          win_b_d = grant_b;
          last_d  = grant_b;
          if (grant_b) begin
            address_d = b_address;
          end else begin
            address_d = a_address;
            o_data_d  = a_o_data;
            we_d      = a_we;
          end
        end
      end
      S_DATA: begin
        // For A writes this captures the byte the memory held before the write.
        if (win_b_q) begin
          b_ack_d    = 1'b1;
          b_i_data_d = i_data;
        end else begin
          a_ack_d    = 1'b1;
          a_i_data_d = i_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      address_q  <= '0;
      o_data_q   <= '0;
      we_q       <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_i_data_q <= '0;
      b_i_data_q <= '0;
      last_q     <= LAST_INIT;
      win_b_q    <= 1'b0;
    end else begin
      address_q  <= address_d;
      o_data_q   <= o_data_d;
      we_q       <= we_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_i_data_q <= a_i_data_d;
      b_i_data_q <= b_i_data_d;
      last_q     <= last_d;
      win_b_q    <= win_b_d;
    end
  end

  assign address  = address_q;
  assign o_data   = o_data_q;
  assign we       = we_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_i_data = a_i_data_q;
  assign b_i_data = b_i_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int ADDR_W = 20;

  logic              clock;
  logic              reset_n;
  logic              a_req;
  logic [ADDR_W-1:0] a_address;
  logic              a_we;
  logic [7:0]        a_o_data;
  logic              a_ack;
  logic [7:0]        a_i_data;
  logic              b_req;
  logic [ADDR_W-1:0] b_address;
  logic              b_ack;
  logic [7:0]        b_i_data;
  logic [ADDR_W-1:0] address;
  logic [7:0]        o_data;
  logic              we;
  logic [7:0]        i_data;

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .LAST_INIT(1'b0)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_address(a_address), .a_we(a_we), .a_o_data(a_o_data),
    .a_ack(a_ack), .a_i_data(a_i_data),
    .b_req(b_req), .b_address(b_address), .b_ack(b_ack), .b_i_data(b_i_data),
    .address(address), .o_data(o_data), .we(we), .i_data(i_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous byte memory with read-before-write.
  always @(posedge clock) begin
    if (we) mem[address] <= o_data;
    i_data <= mem[address];
  end

  always @(negedge clock) if (we === 1'b1) we_cnt++;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL rst_we got %0b exp 0", we); end
    n_vec++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL rst_a_ack got %0b exp 0", a_ack); end
    n_vec++; if (b_ack !== 1'b0) begin n_err++; $display("FAIL rst_b_ack got %0b exp 0", b_ack); end
    n_vec++; if (address !== 20'h0) begin n_err++; $display("FAIL rst_address got %h exp 0", address); end
    n_vec++; if (o_data !== 8'h0) begin n_err++; $display("FAIL rst_o_data got %h exp 0", o_data); end
    n_vec++; if (a_i_data !== 8'h0) begin n_err++; $display("FAIL rst_a_i_data got %h exp 0", a_i_data); end
    n_vec++; if (b_i_data !== 8'h0) begin n_err++; $display("FAIL rst_b_i_data got %h exp 0", b_i_data); end
    reset_n = 1'b1;
  endtask

  task automatic test_a_write_read();
    int we0;
    we0 = we_cnt;
    a_req = 1'b1; a_we = 1'b1; a_address = 20'h12345; a_o_data = 8'hA5;
    tick();
    n_vec++; if (we !== 1'b1) begin n_err++; $display("FAIL wr_we_e0 got %0b exp 1", we); end
    n_vec++; if (address !== 20'h12345) begin n_err++; $display("FAIL wr_address got %h exp 12345", address); end
    n_vec++; if (o_data !== 8'hA5) begin n_err++; $display("FAIL wr_o_data got %h exp a5", o_data); end
    tick();
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL wr_we_e1 got %0b exp 0", we); end
    n_vec++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL wr_ack_early got %0b exp 0", a_ack); end
    tick();
    n_vec++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL wr_ack got %0b exp 1", a_ack); end
    n_vec++; if (a_i_data !== 8'h5A) begin n_err++; $display("FAIL wr_rbw_data got %h exp 5a", a_i_data); end
    a_req = 1'b0;
    tick();
    n_vec++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL wr_ack_end got %0b exp 0", a_ack); end
    n_vec++; if (we_cnt - we0 !== 1) begin n_err++; $display("FAIL wr_we_cycles got %0d exp 1", we_cnt - we0); end
    a_req = 1'b1; a_we = 1'b0;
    tick();
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL rd_we got %0b exp 0", we); end
    tick();
    tick();
    n_vec++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL rd_ack got %0b exp 1", a_ack); end
    n_vec++; if (a_i_data !== 8'hA5) begin n_err++; $display("FAIL rd_data got %h exp a5", a_i_data); end
    a_req = 1'b0;
    tick();
  endtask

  task automatic test_b_read();
    int we0;
    we0 = we_cnt;
    b_req = 1'b1; b_address = 20'h00400;
    tick();
    n_vec++; if (address !== 20'h00400) begin n_err++; $display("FAIL b_address got %h exp 00400", address); end
    tick();
    n_vec++; if (b_ack !== 1'b0) begin n_err++; $display("FAIL b_ack_early got %0b exp 0", b_ack); end
    tick();
    n_vec++; if (b_ack !== 1'b1) begin n_err++; $display("FAIL b_ack got %0b exp 1", b_ack); end
    n_vec++; if (b_i_data !== 8'h3C) begin n_err++; $display("FAIL b_data got %h exp 3c", b_i_data); end
    n_vec++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL b_a_ack got %0b exp 0", a_ack); end
    b_req = 1'b0;
    tick();
    n_vec++; if (b_ack !== 1'b0) begin n_err++; $display("FAIL b_ack_end got %0b exp 0", b_ack); end
    n_vec++; if (we_cnt != we0) begin n_err++; $display("FAIL b_we_cycles got %0d exp 0", we_cnt - we0); end
  endtask

  task automatic test_round_robin();
    logic exp_b;
    apply_reset();
    a_req = 1'b1; a_we = 1'b0; a_address = 20'h00001;
    b_req = 1'b1; b_address = 20'h00002;
    for (int g = 0; g < 6; g++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_b = 1'b1;
`else
      exp_b = (g % 2 == 0);
`endif
      tick();
      tick();
      tick();
      n_vec++; if (b_ack !== exp_b) begin n_err++; $display("FAIL rr_b_ack[%0d] got %0b exp %0b", g, b_ack, exp_b); end
      n_vec++; if (a_ack !== !exp_b) begin n_err++; $display("FAIL rr_a_ack[%0d] got %0b exp %0b", g, a_ack, !exp_b); end
      if (exp_b) begin
        n_vec++; if (b_i_data !== 8'h22) begin n_err++; $display("FAIL rr_b_data[%0d] got %h exp 22", g, b_i_data); end
      end else begin
        n_vec++; if (a_i_data !== 8'h11) begin n_err++; $display("FAIL rr_a_data[%0d] got %h exp 11", g, a_i_data); end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    a_req = 1'b1; a_we = 1'b1; a_address = 20'h00010; a_o_data = 8'hFF;
    tick();
    n_vec++; if (we !== 1'b1) begin n_err++; $display("FAIL ab_we_pre got %0b exp 1", we); end
    reset_n = 1'b0;
    #1;
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL ab_we_now got %0b exp 0", we); end
    n_vec++; if (address !== 20'h0) begin n_err++; $display("FAIL ab_address got %h exp 0", address); end
    a_req = 1'b0; a_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL ab_ack[%0d] got %0b exp 0", i, a_ack); end
    end
    reset_n = 1'b1;
    tick();
    n_vec++; if (mem[20'h00010] !== 8'h77) begin n_err++; $display("FAIL ab_mem got %h exp 77", mem[20'h00010]); end
    a_req = 1'b1;
    tick();
    tick();
    tick();
    n_vec++; if (a_i_data !== 8'h77) begin n_err++; $display("FAIL ab_readback got %h exp 77", a_i_data); end
    a_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    a_req = 1'b1; a_we = 1'b0; a_address = 20'h00001;
    tick();
    tick();
    tick();
    n_vec++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL bb_ack_e2 got %0b exp 1", a_ack); end
    a_address = 20'h00002;
    tick();
    n_vec++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL bb_ack_e3 got %0b exp 0", a_ack); end
    n_vec++; if (address !== 20'h00002) begin n_err++; $display("FAIL bb_address_e3 got %h exp 00002", address); end
    tick();
    n_vec++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL bb_ack_e4 got %0b exp 0", a_ack); end
    tick();
    n_vec++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL bb_ack_e5 got %0b exp 1", a_ack); end
    n_vec++; if (a_i_data !== 8'h22) begin n_err++; $display("FAIL bb_data_e5 got %h exp 22", a_i_data); end
    a_req = 1'b0;
    tick();
    n_vec++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL bb_ack_e6 got %0b exp 0", a_ack); end
  endtask

  task automatic test_addr_change();
    a_req = 1'b1; a_we = 1'b0; a_address = 20'h00001;
    tick();
    a_address = 20'h00002;
    tick();
    n_vec++; if (address !== 20'h00001) begin n_err++; $display("FAIL ac_address_e1 got %h exp 00001", address); end
    tick();
    n_vec++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL ac_ack got %0b exp 1", a_ack); end
    n_vec++; if (a_i_data !== 8'h11) begin n_err++; $display("FAIL ac_data got %h exp 11", a_i_data); end
    a_req = 1'b0;
    tick();
    n_vec++; if (address !== 20'h00001) begin n_err++; $display("FAIL ac_idle_address got %h exp 00001", address); end
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL ac_idle_we got %0b exp 0", we); end
  endtask

  initial begin
    reset_n = 1'b0;
    a_req = 1'b0; a_address = '0; a_we = 1'b0; a_o_data = '0;
    b_req = 1'b0; b_address = '0;
    mem[20'h12345] = 8'h5A;
    mem[20'h00400] = 8'h3C;
    mem[20'h00010] = 8'h77;
    mem[20'h00001] = 8'h11;
    mem[20'h00002] = 8'h22;
    mem[20'h00000] = 8'h00;
    test_reset();
    test_a_write_read();
    test_b_read();
    test_round_robin();
    test_reset_abort();
    test_back_to_back();
    test_addr_change();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
